// File: rtl/divisor_seq_if.sv
// -----------------------------------------------------------------------------
// divisor_seq_if
//   Bus between the control unit (master) and the sequential divider (slave).
//
//   Handshake: iniciar is a one-cycle request. It is accepted only on a rising
//   edge where the divider is idle (ocupado low, estado == OCIOSO); a request
//   seen while ocupado is high, including the cycle pronto is high, is dropped.
//   ocupado is therefore the inverse of "ready". pronto is a one-cycle
//   completion strobe. quociente/resto/div_zero are valid while pronto is high
//   and stay stable until the next accepted request.
//
//   Signals:
//     iniciar    master->slave  start request
//     dividendo  master->slave  signed dividend, sampled on the accepting edge
//     divisor    master->slave  signed divisor, sampled on the accepting edge
//     sem_sinal  master->slave  unsigned-divide select, present only when
//                               DIVISOR_SEM_SINAL_EN is defined
//     quociente  slave->master  quotient (to LO)
//     resto      slave->master  remainder (to HI)
//     ocupado    slave->master  busy from the accepting edge through pronto
//     pronto     slave->master  single-cycle completion pulse
//     div_zero   slave->master  last operation had a zero divisor
//     estado     slave->master  FSM state, debug visibility only
//
//   Optional macro: DIVISOR_SEM_SINAL_EN.
// -----------------------------------------------------------------------------
interface divisor_seq_if #(
  parameter int LARGURA = 32
) ();
  logic               iniciar;
  logic [LARGURA-1:0] dividendo;
  logic [LARGURA-1:0] divisor;
`ifdef DIVISOR_SEM_SINAL_EN
  logic               sem_sinal;
`endif
  logic [LARGURA-1:0] quociente;
  logic [LARGURA-1:0] resto;
  logic               ocupado;
  logic               pronto;
  logic               div_zero;
  logic [1:0]         estado;

  modport master (
    output iniciar,
    output dividendo,
    output divisor,
`ifdef DIVISOR_SEM_SINAL_EN
    output sem_sinal,
`endif
    input  quociente,
    input  resto,
    input  ocupado,
    input  pronto,
    input  div_zero,
    input  estado
  );

  modport slave (
    input  iniciar,
    input  dividendo,
    input  divisor,
`ifdef DIVISOR_SEM_SINAL_EN
    input  sem_sinal,
`endif
    output quociente,
    output resto,
    output ocupado,
    output pronto,
    output div_zero,
    output estado
  );
endinterface

// File: rtl/divisor_seq.sv
// -----------------------------------------------------------------------------
// divisor_seq
//   Multicycle signed integer divider for the DIV instruction. Restoring
//   shift-subtract on sign-magnitude operands, one quotient bit per clock.
//   Quotient truncates toward zero, remainder takes the dividend's sign.
//
//   Latency (accepting edge = edge 0):
//     normal divide : pronto high in the cycle after edge LARGURA+1
//     zero divisor  : pronto high in the cycle after edge 1
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; abandons any operation silently
//     bus    divisor_seq_if.slave (iniciar, dividendo, divisor, [sem_sinal],
//            quociente, resto, ocupado, pronto, div_zero, estado)
//
//   Parameter:
//     LARGURA  operand/result width, >= 2
//
//   Optional macro: DIVISOR_SEM_SINAL_EN adds bus.sem_sinal; when high on the
//   accepting edge the operation is an unsigned divide (DIVU).
// -----------------------------------------------------------------------------
module divisor_seq #(
  parameter int LARGURA = 32
) (
  input  logic         clk,
  input  logic         reset,
  divisor_seq_if.slave bus
);

  localparam int CW = $clog2(LARGURA);
  localparam logic [CW-1:0] CNT_INI = CW'(LARGURA - 1);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] ITERA  = 2'd1;
  localparam logic [1:0] AJUSTA = 2'd2;
  localparam logic [1:0] FIM    = 2'd3;

  logic [1:0]         estado_q;
  logic [CW-1:0]      cnt_q;
  logic [LARGURA-1:0] dvd_q;      // dividend magnitude, shifts out MSB-first and collects quotient bits
  logic [LARGURA-1:0] dsr_q;      // divisor magnitude
  logic [LARGURA-1:0] rem_q;      // partial remainder
  logic               sinal_q_q;  // quotient must be negated
  logic               sinal_r_q;  // remainder must be negated
  logic [LARGURA-1:0] quociente_q;
  logic [LARGURA-1:0] resto_q;
  logic               div_zero_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning on the accepting edge
  // ---------------------------------------------------------------------------
  logic               neg_dvd;
  logic               neg_dsr;
  logic [LARGURA-1:0] mag_dvd;
  logic [LARGURA-1:0] mag_dsr;
  logic               divisor_nulo;

  always_comb begin
    neg_dvd = bus.dividendo[LARGURA-1];
    neg_dsr = bus.divisor[LARGURA-1];
`ifdef DIVISOR_SEM_SINAL_EN
    // Unsigned divide: treat the MSB as magnitude, never negate.
    if (bus.sem_sinal) begin
      neg_dvd = 1'b0;
      neg_dsr = 1'b0;
    end
`endif
    // The most-negative value negates to itself, which read as unsigned is
    // exactly 2^(LARGURA-1): the magnitude is still correct.
    mag_dvd      = neg_dvd ? -bus.dividendo : bus.dividendo;
    mag_dsr      = neg_dsr ? -bus.divisor   : bus.divisor;
    divisor_nulo = (bus.divisor == '0);
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value fits LARGURA+1 bits and the trial difference lies within
  // a LARGURA+1-bit signed range; its MSB is the borrow.
  // ---------------------------------------------------------------------------
  logic [LARGURA:0] desloc;
  logic [LARGURA:0] dif;
  logic             bit_q;

  always_comb begin
    desloc = {rem_q, dvd_q[LARGURA-1]};
    dif    = desloc - {1'b0, dsr_q};
    bit_q  = ~dif[LARGURA];
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      sinal_q_q   <= 1'b0;
      sinal_r_q   <= 1'b0;
      quociente_q <= '0;
      resto_q     <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            if (divisor_nulo) begin
              // Zero divisor: results are zero. The path runs through AJUSTA
              // with zeroed magnitudes so pronto lands one cycle after
              // acceptance; AJUSTA simply rewrites the same zeros.
              div_zero_q  <= 1'b1;
              quociente_q <= '0;
              resto_q     <= '0;
              dvd_q       <= '0;
              rem_q       <= '0;
              sinal_q_q   <= 1'b0;
              sinal_r_q   <= 1'b0;
              estado_q    <= AJUSTA;
            end else begin
              div_zero_q <= 1'b0;
              dvd_q      <= mag_dvd;
              dsr_q      <= mag_dsr;
              rem_q      <= '0;
              sinal_q_q  <= neg_dvd ^ neg_dsr;
              sinal_r_q  <= neg_dvd;
              cnt_q      <= CNT_INI;
              estado_q   <= ITERA;
            end
          end
        end

        ITERA: begin
          rem_q <= bit_q ? dif[LARGURA-1:0] : desloc[LARGURA-1:0];
          dvd_q <= {dvd_q[LARGURA-2:0], bit_q};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            estado_q <= AJUSTA;
          end
        end

        AJUSTA: begin
          quociente_q <= sinal_q_q ? -dvd_q : dvd_q;
          resto_q     <= sinal_r_q ? -rem_q : rem_q;
          estado_q    <= FIM;
        end

        FIM: begin
          estado_q <= OCIOSO;
        end

        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. pronto/ocupado decode the registered state, so iniciar in FIM is
  // ignored naturally (only OCIOSO looks at it).
  // ---------------------------------------------------------------------------
  assign bus.quociente = quociente_q;
  assign bus.resto     = resto_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.pronto    = (estado_q == FIM);
  assign bus.ocupado   = (estado_q != OCIOSO);
  assign bus.estado    = estado_q;

endmodule

// File: tb/tb_divisor_seq.sv
// -----------------------------------------------------------------------------
// tb_divisor_seq
//   Directed bench for divisor_seq at LARGURA=32. Expected results are hand
//   computed; define DIVISOR_SEM_SINAL_EN to also exercise the DIVU option.
// -----------------------------------------------------------------------------
module tb_divisor_seq;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  divisor_seq_if #(.LARGURA(W)) bus ();

  divisor_seq #(.LARGURA(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

`ifdef DIVISOR_SEM_SINAL_EN
  logic sem_flag = 1'b0;
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a one-cycle request; returns at the negedge after the accepting
  // edge (cycle 0 of the operation) with operands scrambled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.iniciar   = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
`ifdef DIVISOR_SEM_SINAL_EN
    bus.sem_sinal = sem_flag;
`endif
    @(negedge clk);
    bus.iniciar   = 1'b0;
    bus.dividendo = $urandom;
    bus.divisor   = $urandom;
  endtask

  // Waits (bounded) for pronto; lat is the cycle index where pronto is seen.
  task automatic wait_done(input int base, output int lat, output int ocnt);
    lat  = base;
    ocnt = 0;
    while (bus.pronto !== 1'b1 && lat < 200) begin
      ocnt += int'(bus.ocupado);
      @(negedge clk);
      lat++;
    end
    ocnt += int'(bus.ocupado);
    chk("pronto_seen", bus.pronto, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dz, input int lat_exp);
    int lat;
    int ocnt;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    exp_q.push_back(q);
    exp_q.push_back(r);
    start_op(a, b);
    wait_done(0, lat, ocnt);
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    chk({tag, "_q"},    bus.quociente, eq);
    chk({tag, "_r"},    bus.resto, er);
    chk({tag, "_dz"},   bus.div_zero, dz);
    chk({tag, "_lat"},  lat + 1, lat_exp);
    chk({tag, "_busy"}, ocnt, lat_exp);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.pronto, 0);
    chk({tag, "_idle"},  bus.ocupado, 0);
    chk({tag, "_hold"},  bus.quociente, eq);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int ocnt;
    int pcnt;

    reset         = 1'b1;
    bus.iniciar   = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
`ifdef DIVISOR_SEM_SINAL_EN
    bus.sem_sinal = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_q",      bus.quociente, 0);
    chk("rst_r",      bus.resto, 0);
    chk("rst_pronto", bus.pronto, 0);
    chk("rst_busy",   bus.ocupado, 0);
    chk("rst_dz",     bus.div_zero, 0);
    chk("rst_estado", bus.estado, 0);
    reset = 1'b0;

    // Basic and sign combinations
    run_op("basic",  32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 34);
    run_op("neg_a",  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
    run_op("neg_b",  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34);
    run_op("neg_ab", 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 34);

    // Divide by zero, then a clean divide clears the flag
    run_op("dz",     32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 2);
    run_op("after",  32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 34);

    // Overflow and edge values
    run_op("ovf",    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34);
    run_op("zero_a", 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 34);
    run_op("small",  32'd3,          32'd7,          32'd0,          32'd3,          1'b0, 34);
    run_op("maxpos", 32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 34);
    run_op("minneg", 32'h8000_0000,  32'd3,          32'hD555_5556,  32'hFFFF_FFFE,  1'b0, 34);

    // Start while busy is ignored
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd1);
    start_op(32'd7, 32'd2);
    repeat (9) @(negedge clk);
    bus.iniciar   = 1'b1;
    bus.dividendo = 32'd100;
    bus.divisor   = 32'd7;
    @(negedge clk);
    bus.iniciar = 1'b0;
    wait_done(10, lat, ocnt);
    chk("busy_lat", lat + 1, 34);
    chk("busy_q", bus.quociente, exp_q.pop_front());
    chk("busy_r", bus.resto, exp_q.pop_front());
    @(negedge clk);

    // Reset mid-operation
    start_op(32'd7, 32'd2);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_q",      bus.quociente, 0);
    chk("mid_rst_r",      bus.resto, 0);
    chk("mid_rst_pronto", bus.pronto, 0);
    chk("mid_rst_busy",   bus.ocupado, 0);
    chk("mid_rst_dz",     bus.div_zero, 0);
    reset = 1'b0;
    pcnt = 0;
    repeat (40) begin
      @(negedge clk);
      pcnt += int'(bus.pronto);
    end
    chk("mid_rst_nopulse", pcnt, 0);
    run_op("fresh", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

`ifdef DIVISOR_SEM_SINAL_EN
    sem_flag = 1'b1;
    run_op("divu", 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd0, 1'b0, 34);
    sem_flag = 1'b0;
    run_op("divs", 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
